// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned INSTR_INC = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response bus between the fetch controller and imem.
interface fetch_controller_if #(
    parameter int unsigned WIDTH = 32
);
    logic              imem_req;
    logic [WIDTH-1:0]  imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_target_gen.sv
// Combinational next-sequential PC and word-aligned PC-relative branch target.
module pc_target_gen
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_branch_pc,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_pc_inc,
    output logic [WIDTH-1:0] o_target
);
    logic [WIDTH-1:0] w_sum;

    assign o_pc_inc = i_pc + WIDTH'(INSTR_INC);
    assign w_sum    = i_branch_pc + i_imm;
    // Low two bits cleared so a misaligned offset still lands on a word boundary.
    assign o_target = {w_sum[WIDTH-1:2], 2'b00};
endmodule

// File: rtl/fetch_controller.sv
// PC sequencing and single-outstanding instruction fetch with branch redirect/kill.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_controller_if.master   bus,
    output logic                 instr_valid,
    output logic [INSTR_W-1:0]   instr,
    output logic [WIDTH-1:0]     instr_pc,
    input  logic                 stall,
    input  logic                 PCsrc,
    input  logic [WIDTH-1:0]     ImmOp,
    input  logic [WIDTH-1:0]     branch_pc
);
    fetch_state_e        r_state;
    logic [WIDTH-1:0]    r_pc;
    logic [WIDTH-1:0]    r_fetch_pc;
    logic                r_kill;
    logic                r_instr_valid;
    logic [INSTR_W-1:0]  r_instr;
    logic [WIDTH-1:0]    r_instr_pc;

    logic [WIDTH-1:0]    w_pc_inc;
    logic [WIDTH-1:0]    w_target;

    pc_target_gen #(.WIDTH(WIDTH)) u_pc_target_gen (
        .i_pc        (r_pc),
        .i_branch_pc (branch_pc),
        .i_imm       (ImmOp),
        .o_pc_inc    (w_pc_inc),
        .o_target    (w_target)
    );

    // Request is a pure decode of registered state, so no input reaches imem combinationally.
    assign bus.imem_req  = (r_state == REQ);
    assign bus.imem_addr = r_pc;

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_VECTOR;
            r_fetch_pc    <= RESET_VECTOR;
            r_kill        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= REQ;
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        r_fetch_pc <= r_pc;
                        r_pc       <= w_pc_inc;
                        r_state    <= WAIT;
                        // Granted wrong-path fetch must be drained before refetching.
                        if (PCsrc) r_kill <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (r_kill || PCsrc) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                        end else begin
                            r_instr       <= bus.imem_rdata;
                            r_instr_pc    <= r_fetch_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= VALID;
                        end
                    end else if (PCsrc) begin
                        r_kill <= 1'b1;
                    end
                end
                VALID: begin
                    if (PCsrc || !stall) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= REQ;
                    end
                end
            endcase
            // Redirect wins over any sequential pc update made above.
            if (PCsrc) r_pc <= w_target;
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with a 1-cycle imem responder.
module tb_fetch_controller;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic [31:0] branch_pc;

    fetch_controller_if #(.WIDTH(32)) bus ();

    fetch_controller #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .stall       (stall),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp),
        .branch_pc   (branch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        gnt_en;
    logic        rsp_en;
    logic        pend;
    logic [31:0] pend_addr;

    // Memory image: one recognisable ADDI at 0xC, otherwise address-tagged words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_000C) ? 32'h0050_0093 : {a[23:0], 8'h13};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then drive the memory response for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pend && rsp_en) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr);
            pend            = 1'b0;
        end else begin
            bus.imem_rvalid = 1'b0;
        end
        bus.imem_gnt = bus.imem_req && gnt_en && !pend;
        if (bus.imem_gnt) begin
            pend      = 1'b1;
            pend_addr = bus.imem_addr;
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] word, input string tag);
        check_eq({tag, "_req"},  32'(bus.imem_req), 32'd1);
        check_eq({tag, "_addr"}, bus.imem_addr, pc);
        tick();
        check_eq({tag, "_wait_valid"}, 32'(instr_valid), 32'd0);
        tick();
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check_eq({tag, "_pc"},    instr_pc, pc);
        check_eq({tag, "_instr"}, instr, word);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0; branch_pc = '0;
        gnt_en = 1'b1; rsp_en = 1'b1; pend = 1'b0; pend_addr = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",   32'(bus.imem_req), 32'd0);
        check_eq("rst_addr",  bus.imem_addr, 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc",    instr_pc, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch, one instruction every third cycle.
        tick();
        expect_fetch(32'h0, 32'h0000_0013, "seq0");
        tick();
        check_eq("seq1_valid_drop", 32'(instr_valid), 32'd0);
        expect_fetch(32'h4, 32'h0000_0413, "seq1");
        tick();
        expect_fetch(32'h8, 32'h0000_0813, "seq2");
        tick();
        expect_fetch(32'hC, 32'h0050_0093, "seq3");

        // Stall holds the instruction and blocks new requests.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_instr", instr, 32'h0050_0093);
            check_eq("stall_pc",    instr_pc, 32'hC);
            check_eq("stall_req",   32'(bus.imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check_eq("resume_valid", 32'(instr_valid), 32'd0);
        check_eq("resume_addr",  bus.imem_addr, 32'h10);

        // Redirect during WAIT: in-flight word for 0x10 is dropped, refetch from 0x08.
        rsp_en = 1'b0;
        tick();
        PCsrc = 1'b1; branch_pc = 32'h10; ImmOp = 32'hFFFF_FFF8;
        tick();
        PCsrc = 1'b0; rsp_en = 1'b1;
        check_eq("kill_wait_req", 32'(bus.imem_req), 32'd0);
        tick();
        check_eq("kill_rvalid_req", 32'(bus.imem_req), 32'd0);
        tick();
        check_eq("kill_drop_valid", 32'(instr_valid), 32'd0);
        expect_fetch(32'h8, 32'h0000_0813, "redir_wait");
        tick();
        check_eq("redir_next_addr", bus.imem_addr, 32'hC);

        // Redirect coincident with grant; misaligned offset gets masked.
        PCsrc = 1'b1; branch_pc = 32'h100; ImmOp = 32'h23;
        tick();
        PCsrc = 1'b0;
        check_eq("gntkill_req", 32'(bus.imem_req), 32'd0);
        tick();
        check_eq("gntkill_drop_valid", 32'(instr_valid), 32'd0);
        expect_fetch(32'h120, 32'h0001_2013, "redir_gnt");

        // Redirect from VALID overrides stall; fetch at top of address space wraps.
        stall = 1'b1; PCsrc = 1'b1; branch_pc = 32'hFFFF_FFF0; ImmOp = 32'hC;
        tick();
        stall = 1'b0; PCsrc = 1'b0;
        check_eq("valid_redir_valid", 32'(instr_valid), 32'd0);
        expect_fetch(32'hFFFF_FFFC, 32'hFFFF_FC13, "wrap");
        tick();
        check_eq("wrap_next_req",  32'(bus.imem_req), 32'd1);
        check_eq("wrap_next_addr", bus.imem_addr, 32'h0);

        // Async reset in WAIT; stale response after release must be ignored.
        rsp_en = 1'b0;
        tick();
        check_eq("prerst_addr", bus.imem_addr, 32'h4);
        rst_n = 1'b0;
        #1;
        check_eq("arst_req",   32'(bus.imem_req), 32'd0);
        check_eq("arst_addr",  bus.imem_addr, 32'h0);
        check_eq("arst_valid", 32'(instr_valid), 32'd0);
        check_eq("arst_instr", instr, 32'h0);
        check_eq("arst_pc",    instr_pc, 32'h0);
        tick();
        rst_n = 1'b1; rsp_en = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; pend = 1'b0;
        tick();
        check_eq("stale_valid", 32'(instr_valid), 32'd0);
        expect_fetch(32'h0, 32'h0000_0013, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the program counter and instruction fetch for the core. Owns the PC register, issues one outstanding request at a time to instruction memory, and presents fetched instructions to decode with a valid/stall handshake. Applies branch redirects from execute (PCsrc, ImmOp) as PC-relative targets, discarding any in-flight or held wrong-path fetch.

## Interface
- WIDTH, 32, address/PC width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address, stable while imem_req=1 and imem_gnt=0 unless a redirect occurs
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid (earliest the cycle after gnt)
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  fetched instruction
- instr_pc  out  WIDTH  address of instr
- stall  in  1  decode not ready; instruction consumed when instr_valid=1 and stall=0
- PCsrc  in  1  one-cycle branch-taken pulse from execute
- ImmOp  in  WIDTH  branch offset, sign-extended
- branch_pc  in  WIDTH  PC of the branch instruction

## Operation
- States: IDLE, REQ, WAIT, VALID.
- Reset: state IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, kill=0. Async assertion mid-operation forces these immediately; an rvalid for a pre-reset request is ignored (rvalid only honoured in WAIT).
- IDLE -> REQ unconditionally next cycle.
- REQ: imem_req=1, imem_addr=pc. On gnt: fetch_pc<=pc, pc<=pc+4, -> WAIT.
- WAIT: imem_req=0. On rvalid: if kill, clear kill, -> REQ; else instr<=rdata, instr_pc<=fetch_pc, instr_valid<=1, -> VALID.
- VALID: hold instr/instr_pc. If stall=0: instr_valid<=0, -> REQ. If stall=1: stay.
- Redirect (PCsrc=1): target = (branch_pc + ImmOp) with bits [1:0] cleared; pc<=target.
  - REQ, no gnt: stay REQ; imem_addr=target next cycle.
  - REQ with gnt same cycle: -> WAIT with kill=1; pc<=target (not target+4).
  - WAIT, no rvalid: kill<=1, stay WAIT.
  - WAIT with rvalid same cycle: response dropped, -> REQ.
  - VALID: instr_valid<=0, -> REQ, regardless of stall.
  - IDLE: pc<=target, -> REQ.
- Redirect overrides all other pc updates in the same cycle.
- Arithmetic: all PC math modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- All outputs registered except imem_req/imem_addr (decoded from state/pc registers, no input-to-output combinational path).
- Minimum latency gnt -> instr_valid: 2 cycles (gnt at t, rvalid at t+1, instr_valid at t+2).
- Unstalled throughput: one instruction per 3 cycles with 1-cycle memory.
- Redirect at cycle t: first request to target visible on imem_addr at t+1.
- Exactly one request outstanding; no request while kill=1.

## Structure
- Package fetch_pkg: state enum (IDLE, REQ, WAIT, VALID), INSTR_INC=4, default RESET_VECTOR.
- Sub-module pc_target_gen: combinational pc+4 and branch_pc+ImmOp with alignment masking; controller holds all state.

## Test plan
- Reset release, mem grants immediately, rvalid next cycle -> imem_addr 0x0, 0x4, 0x8 in order; instr_pc matches each; instr_valid every 3rd cycle.
- stall=1 for 5 cycles while instr 0x00500093 valid -> instr/instr_pc held, imem_req=0; resumes fetch at pc+4 after release.
- PCsrc=1, branch_pc=0x10, ImmOp=0xFFFF_FFF8 during WAIT -> returning rdata dropped, next imem_addr=0x08, instr_valid never asserted for dropped word.
- PCsrc coinciding with gnt in REQ -> kill set, granted response discarded, next request to target.
- pc=0xFFFF_FFFC granted -> next request address 0x0.
- rst_n asserted in WAIT then rvalid after release -> rvalid ignored, first request to RESET_VECTOR.
